// File: rtl/vga_tile_renderer.sv
// Tile-based pixel pipeline behind the VGA timing generator: tilemap lookup,
// pattern lookup, palette, with sync and blank delayed to stay aligned with colour.
module vga_tile_renderer #(
  parameter int X_OFFSET    = 96,
  parameter int Y_OFFSET    = 0,
  parameter int MAP_COLS    = 28,
  parameter int MAP_ROWS    = 30,
  parameter int SCALE_SHIFT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [1:0]  h_state,
  input  logic [1:0]  v_state,
  output logic [9:0]  map_addr,
  input  logic [3:0]  map_data,
  output logic [9:0]  pat_addr,
  input  logic [1:0]  pat_data,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        blank,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_BACK  = 2'd1,
    ST_DISP  = 2'd2,
    ST_FRONT = 2'd3
  } axis_state_e;

  localparam int          TILE_SHIFT = 3 + SCALE_SHIFT;
  localparam logic [10:0] MAP_W      = 11'(MAP_COLS << TILE_SHIFT);
  localparam logic [10:0] MAP_H      = 11'(MAP_ROWS << TILE_SHIFT);
  localparam logic [9:0]  COLS_BITS  = 10'(MAP_COLS);

  function automatic logic [11:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return 12'h000;
      2'd1:    return 12'h00F;
      2'd2:    return 12'hFB9;
      default: return 12'hFFF;
    endcase
  endfunction

  // S0: input capture
  logic        s0_valid;
  logic [9:0]  s0_x;
  logic [8:0]  s0_y;
  axis_state_e s0_h, s0_v;

  // NOTE: every clocked block uses non-blocking assignments so all stages
  // advance together on the same edge regardless of block ordering.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid <= 1'b0;
      s0_x     <= '0;
      s0_y     <= '0;
      s0_h     <= ST_SYNC;
      s0_v     <= ST_SYNC;
    end else begin
      s0_valid <= 1'b1;
      s0_x     <= x;
      s0_y     <= y;
      s0_h     <= axis_state_e'(h_state);
      s0_v     <= axis_state_e'(v_state);
    end
  end

  // S1: address generation. dx/dy are two's complement; bit 10 is the sign.
  logic [10:0] dx, dy;
  logic        in_map_c;
  logic [9:0]  map_addr_c;

  assign dx = {1'b0, s0_x} - 11'(X_OFFSET);
  assign dy = {2'b00, s0_y} - 11'(Y_OFFSET);

  assign in_map_c = (s0_h == ST_DISP) && (s0_v == ST_DISP) && (s0_x < 10'd640) &&
                    !dx[10] && (dx < MAP_W) && !dy[10] && (dy < MAP_H);

  // row*MAP_COLS built as a sum of shifted rows, one per set bit of MAP_COLS.
  // NOTE: the accumulator is assigned before the loop so no latch is inferred.
  always_comb begin
    map_addr_c = 10'(dx >> TILE_SHIFT);
    for (int i = 0; i < 10; i++) begin
      if (COLS_BITS[i]) map_addr_c = map_addr_c + 10'((dy >> TILE_SHIFT) << i);
    end
  end

  logic        s1_valid, s1_in_map;
  logic [2:0]  s1_px, s1_py;
  axis_state_e s1_h, s1_v;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_in_map <= 1'b0;
      s1_px     <= '0;
      s1_py     <= '0;
      s1_h      <= ST_SYNC;
      s1_v      <= ST_SYNC;
      map_addr  <= '0;
    end else begin
      s1_valid  <= s0_valid;
      s1_in_map <= s0_valid && in_map_c;
      s1_px     <= dx[SCALE_SHIFT +: 3];
      s1_py     <= dy[SCALE_SHIFT +: 3];
      s1_h      <= s0_h;
      s1_v      <= s0_v;
      if (s0_valid && in_map_c) map_addr <= map_addr_c;
    end
  end

  // S2: map_data answers the map_addr presented on the previous edge
  logic        s2_valid, s2_in_map;
  axis_state_e s2_h, s2_v;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_in_map <= 1'b0;
      s2_h      <= ST_SYNC;
      s2_v      <= ST_SYNC;
      pat_addr  <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_in_map <= s1_in_map;
      s2_h      <= s1_h;
      s2_v      <= s1_v;
      if (s1_in_map) pat_addr <= {map_data, s1_py, s1_px};
    end
  end

  // S3: capture the colour index answering pat_addr
  logic        s3_valid, s3_in_map;
  logic [1:0]  s3_colour;
  axis_state_e s3_h, s3_v;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      s3_valid  <= 1'b0;
      s3_in_map <= 1'b0;
      s3_colour <= '0;
      s3_h      <= ST_SYNC;
      s3_v      <= ST_SYNC;
    end else begin
      s3_valid  <= s2_valid;
      s3_in_map <= s2_in_map;
      s3_colour <= pat_data;
      s3_h      <= s2_h;
      s3_v      <= s2_v;
    end
  end

  // Output register; prev_v tracks only real outputs so pre-reset state cannot tick.
  axis_state_e prev_v;
  logic        s3_disp;

  assign s3_disp = (s3_h == ST_DISP) && (s3_v == ST_DISP);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= '0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
      prev_v     <= ST_SYNC;
    end else if (!s3_valid) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= '0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= (s3_h != ST_SYNC);
      vsync      <= (s3_v != ST_SYNC);
      rgb        <= (s3_disp && s3_in_map) ? palette(s3_colour) : 12'h000;
      blank      <= !s3_disp;
      frame_tick <= (s3_v == ST_FRONT) && (prev_v == ST_DISP);
      prev_v     <= s3_v;
    end
  end

endmodule
